// File: rtl/reg_pipe_pkg.sv
// Shared defaults and the occupancy-counter width helper for the reg_pipe block.
package reg_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: valid bit plus data register, loaded when the slot ahead can take it.
// Flush drops the valid bit only; the data register keeps its contents.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);
  logic             vld_q;
  logic [WIDTH-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= RST_VAL;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (ld_i) begin
      vld_q <= vld_i;
      dat_q <= dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

// File: rtl/reg_pipe.sv
// Bubble-collapsing register pipeline, DEPTH cycles latency, full throughput; a stage
// accepts whenever it or any stage ahead is empty. Optional flush port: REG_PIPE_FLUSH_EN.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef REG_PIPE_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int CW = cnt_w(DEPTH);

  logic             flush_w;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

`ifdef REG_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // rdy[i]: stage i may load this edge (it is empty, or everything ahead moves on)
  always_comb begin
    logic r;
    rdy = '0;
    r   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !vld[i] | r;
      rdy[i] = r;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      reg_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (rdy[g]),
        .flush_i (flush_w),
        .vld_i   (in_valid),
        .dat_i   (in_data),
        .vld_o   (vld[g]),
        .dat_o   (dat[g])
      );
    end else begin : g_body
      reg_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (rdy[g]),
        .flush_i (flush_w),
        .vld_i   (vld[g-1]),
        .dat_i   (dat[g-1]),
        .vld_o   (vld[g]),
        .dat_o   (dat[g])
      );
    end
  end

  assign in_ready  = rdy[0] & ~flush_w;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush_w) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: tb/tb_reg_pipe.sv
// Directed and random checks of reg_pipe (WIDTH=8, DEPTH=4) against a queue-of-positions model.
module tb_reg_pipe;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;
`ifdef REG_PIPE_FLUSH_EN
  logic       flush;
`endif

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef REG_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int         vectors = 0;
  int         miscompares = 0;
  bit         chk_en = 1'b0;
  // model: per-item stage position and data, head of queue is the oldest item
  int         pq[$];
  logic [7:0] dq[$];
  logic [7:0] outs[$];
  logic       s_ov, s_ir;
  logic [7:0] s_od;
  logic [2:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic fl);
    bit ev, eir;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = id; out_ready = ordy;
`ifdef REG_PIPE_FLUSH_EN
    flush = fl;
`endif
    #1;
    s_ov = out_valid; s_ir = in_ready; s_od = out_data; s_cnt = count;
    ev  = (pq.size() > 0) && (pq[0] == D - 1);
    eir = !fl && ((pq.size() < D) || ordy);
    if (chk_en) begin
      chk("out_valid", 32'(s_ov), 32'(ev));
      chk("in_ready", 32'(s_ir), 32'(eir));
      chk("count", 32'(s_cnt), pq.size());
      if (ev) chk("out_data", 32'(s_od), 32'(dq[0]));
    end
    if (s_ov && ordy && r && !fl) outs.push_back(s_od);
    @(posedge clk);
    if (!r || fl) begin
      pq.delete();
      dq.delete();
    end else begin
      if (ev && ordy) begin
        void'(pq.pop_front());
        void'(dq.pop_front());
      end
      for (int k = 0; k < pq.size(); k++) begin
        int np;
        np = pq[k] + 1;
        if (np > D - 1) np = D - 1;
        if (k > 0 && np > pq[k-1] - 1) np = pq[k-1] - 1;
        pq[k] = np;
      end
      if (iv && eir) begin
        pq.push_back(0);
        dq.push_back(id);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
    flush = 1'b0;
`endif
    // reset state
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 8'h00, 1, 0);
    chk("rst_out_valid", 32'(s_ov), 0);
    chk("rst_in_ready", 32'(s_ir), 1);
    chk("rst_count", 32'(s_cnt), 0);
    chk("rst_out_data", 32'(s_od), 32'h00);

    // single item latency
    cyc(1, 1, 8'hA5, 1, 0);
    chk("a5_cnt0", 32'(s_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 8'h00, 1, 0);
      chk("a5_count", 32'(s_cnt), (k <= 4) ? 1 : 0);
      chk("a5_valid", 32'(s_ov), (k == 4) ? 1 : 0);
      if (k == 4) chk("a5_data", 32'(s_od), 32'hA5);
    end

    // back-to-back stream
    outs.delete();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 1, 8'(i), 1, 0);
      chk("b2b_in_ready", 32'(s_ir), 1);
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h00, 1, 0);
    chk("b2b_n", outs.size(), 16);
    for (int i = 0; i < outs.size() && i < 16; i++) chk("b2b_order", 32'(outs[i]), i + 1);

    // output stall fills the pipe, then release
    outs.delete();
    for (int v = 8'h11; v <= 8'h14; v++) begin
      cyc(1, 1, 8'(v), 0, 0);
      chk("stall_accept", 32'(s_ir), 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 8'h15, 0, 0);
      chk("stall_in_ready", 32'(s_ir), 0);
      chk("stall_count", 32'(s_cnt), 4);
      chk("stall_hold", 32'(s_od), 32'h11);
    end
    cyc(1, 1, 8'h15, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1, 0);
    chk("stall_n", outs.size(), 5);
    for (int i = 0; i < outs.size() && i < 5; i++) chk("stall_order", 32'(outs[i]), 32'h11 + i);

    // full pipe accepts while emitting
    for (int v = 8'h21; v <= 8'h24; v++) cyc(1, 1, 8'(v), 0, 0);
    cyc(1, 1, 8'h25, 1, 0);
    chk("full_in_ready", 32'(s_ir), 1);
    chk("full_count", 32'(s_cnt), 4);
    cyc(1, 0, 8'h00, 0, 0);
    chk("full_count_after", 32'(s_cnt), 4);
    chk("full_next_head", 32'(s_od), 32'h22);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1, 0);

    // reset with items in flight
    for (int v = 8'h31; v <= 8'h33; v++) cyc(1, 1, 8'(v), 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 1, 0);
    chk("rst2_out_valid", 32'(s_ov), 0);
    chk("rst2_in_ready", 32'(s_ir), 1);
    chk("rst2_count", 32'(s_cnt), 0);
    chk("rst2_out_data", 32'(s_od), 32'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), 0);
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1, 0);
    chk("drain_count", 32'(s_cnt), 0);

`ifdef REG_PIPE_FLUSH_EN
    // flush with a pending input
    outs.delete();
    for (int v = 8'h41; v <= 8'h43; v++) cyc(1, 1, 8'(v), 0, 0);
    cyc(1, 1, 8'hEE, 0, 1);
    chk("flush_cnt_before", 32'(s_cnt), 3);
    chk("flush_in_ready", 32'(s_ir), 0);
    cyc(1, 0, 8'h00, 1, 0);
    chk("flush_count", 32'(s_cnt), 0);
    chk("flush_out_valid", 32'(s_ov), 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1, 0);
    chk("flush_no_emerge", outs.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per stage, >=1.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, >=1.
REQ-003 SHALL have parameter RST_VAL, default 0: WIDTH-bit value loaded into every data register on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream item present.
REQ-007 SHALL have port in_ready  output  1  block accepts an item this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream item.
REQ-009 SHALL have port out_valid  output  1  stage DEPTH-1 holds an item.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  item in stage DEPTH-1.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 SHALL hold one valid bit and one WIDTH data register per stage; stage 0 input side, stage DEPTH-1 drives out_valid/out_data directly from registers.
REQ-014 SHALL compute ready[DEPTH] = out_ready and ready[i] = !valid[i] | ready[i+1]; in_ready = ready[0] (combinational chain, no extra skid storage).
REQ-015 SHALL transfer at input when in_valid & in_ready, at output when out_valid & out_ready.
REQ-016 SHALL, when ready[i+1], load stage i+1 with stage i's valid and data; stage 0 loads in_valid/in_data when ready[0].
REQ-017 SHALL give latency DEPTH cycles: item accepted at edge t is out_valid after edge t+DEPTH-1 when empty and never stalled (visible in cycle t+DEPTH counting acceptance as cycle 0).
REQ-018 SHALL sustain one item per cycle when out_ready held high.
REQ-019 SHALL collapse bubbles: while output stalled, upstream items advance into empty stages.
REQ-020 SHALL preserve order; no item dropped or duplicated.
REQ-021 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL update count: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither; count never exceeds DEPTH nor underflows.
REQ-023 SHALL, when full (count==DEPTH) with out_ready=1, keep in_ready=1 and accept simultaneously.
REQ-024 SHALL leave data registers of empty stages unspecified except after reset.

Reset
REQ-025 SHALL, on rising clk with rst=0, clear all valid bits, set count=0, load all data registers with RST_VAL; takes priority over every transfer.
REQ-026 SHALL, after reset, present out_valid=0, out_data=RST_VAL, in_ready=1; items in flight at reset are discarded.

Configuration
REQ-027 SHALL, with REG_PIPE_FLUSH_EN defined, add input port flush (1 bit); flush=1 at an edge clears all valid bits and count, data unchanged, in_ready forced 0 that cycle, any in_valid item discarded; rst has priority over flush.
REQ-028 SHALL, without REG_PIPE_FLUSH_EN, have no flush port and behave as flush=0.

Structure
REQ-029 SHALL place default WIDTH/DEPTH constants and a count-width helper function in package reg_pipe_pkg.
REQ-030 SHALL implement one stage as sub-module reg_pipe_stage (valid + data register, load enable, reset value), instantiated DEPTH times by generate.

Verification (WIDTH=8, DEPTH=4, RST_VAL=0)
REQ-031 SHALL cover: rst=0 two cycles -> out_valid=0, count=0, in_ready=1, out_data=0x00; repeat with 3 items in flight -> same result.
REQ-032 SHALL cover: single 0xA5 pushed cycle 0, out_ready=1 -> out_valid=1 with 0xA5 in cycle 4 only; count=1 cycles 1-4, 0 cycle 5.
REQ-033 SHALL cover: 0x01..0x10 back-to-back, out_ready=1 -> outputs 0x01..0x10 consecutive from cycle 4, in_ready constantly 1.
REQ-034 SHALL cover: out_ready=0, push 0x11..0x15 -> 0x11..0x14 accepted, in_ready=0 after 4th, count=4, out_data=0x11 stable; release -> 0x11,0x12,0x13,0x14,0x15 in order.
REQ-035 SHALL cover: full with out_ready=1 and in_valid=1 -> in_ready=1, count stays 4, one item out and one in.
REQ-036 SHALL cover (REG_PIPE_FLUSH_EN): count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, pushed item never emerges.
